// File: rtl/bcd_digit_loader_if.sv
// Handshake bundle between a digit source, the bcd_digit_loader and the
// downstream BCD-to-binary converter.
interface bcd_digit_loader_if;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       digit_ready;
    logic [5:0] bcd_out;
    logic       g_n;
    logic       out_valid;
    logic       out_ack;
    logic       err;

    modport master (
        output digit_in, digit_valid, out_ack,
        input  digit_ready, bcd_out, g_n, out_valid, err
    );

    modport slave (
        input  digit_in, digit_valid, out_ack,
        output digit_ready, bcd_out, g_n, out_valid, err
    );
endinterface

// File: rtl/bcd_digit_loader.sv
// Collects two BCD digits into a 6-bit word {tens[1:0], units} for the converter.
// Optional single-digit timeout is enabled by defining DIGIT_TIMEOUT_EN.
module bcd_digit_loader #(
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    bcd_digit_loader_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, FIRST, HOLD, ERROR} state_t;

    state_t     state;
    logic [3:0] first_digit;
    logic [5:0] bcd_q;
    logic       g_n_q;
    logic       out_valid_q;
    logic       err_q;
    logic       ready;
    logic       accept;

    // Elaboration-time guard: the counter must be able to reach TIMEOUT-1.
    if ((2 ** TMO_W) < TIMEOUT) begin : g_bad_cfg
        $error("bcd_digit_loader: TMO_W too narrow for TIMEOUT");
    end

`ifdef DIGIT_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
`endif

    assign ready  = ((state == IDLE) || (state == FIRST)) && !clear;
    assign accept = bus.digit_valid && ready;

    assign bus.digit_ready = ready;
    assign bus.bcd_out     = bcd_q;
    assign bus.g_n         = g_n_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.err         = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            first_digit <= '0;
            bcd_q       <= '0;
            g_n_q       <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef DIGIT_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else if (clear) begin
            state       <= IDLE;
            first_digit <= '0;
            bcd_q       <= '0;
            g_n_q       <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.digit_in <= 4'd9) begin
                            first_digit <= bus.digit_in;
                            state       <= FIRST;
`ifdef DIGIT_TIMEOUT_EN
                            tmo_cnt     <= '0;
`endif
                        end else begin
                            err_q <= 1'b1;
                            state <= ERROR;
                        end
                    end
                end
                FIRST: begin
                    if (accept) begin
                        if ((bus.digit_in <= 4'd9) && (first_digit <= 4'd3)) begin
                            bcd_q       <= {first_digit[1:0], bus.digit_in};
                            out_valid_q <= 1'b1;
                            g_n_q       <= 1'b0;
                            state       <= HOLD;
                        end else begin
                            err_q <= 1'b1;
                            state <= ERROR;
                        end
                    end
`ifdef DIGIT_TIMEOUT_EN
                    // A digit arriving on the timeout cycle wins over the timeout.
                    else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        bcd_q       <= {2'b00, first_digit};
                        out_valid_q <= 1'b1;
                        g_n_q       <= 1'b0;
                        state       <= HOLD;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                HOLD: begin
                    if (bus.out_ack) begin
                        out_valid_q <= 1'b0;
                        g_n_q       <= 1'b1;
                        state       <= IDLE;
                    end
                end
                ERROR: begin
                    err_q       <= 1'b1;
                    g_n_q       <= 1'b1;
                    out_valid_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
